// File: rtl/wb_regfile.sv
// Writeback result select, architectural register file with two read ports,
// PC redirect on register-targeted PC writes and a retired-writeback counter.
// Define WB_BYPASS_EN to forward the committing result to same-cycle reads.
module wb_regfile #(
    parameter int SIZE     = 32,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            RegWriteW,
    input  logic            MemToRegW,
    input  logic            PCSrcW,
    input  logic [4:0]      WA3W,
    input  logic [SIZE-1:0] ALUOutW,
    input  logic [SIZE-1:0] ReadDataW,
    input  logic [4:0]      RA1D,
    input  logic [4:0]      RA2D,
    output logic [SIZE-1:0] RD1D,
    output logic [SIZE-1:0] RD2D,
    output logic [SIZE-1:0] ResultW,
    output logic            PCRedirectW,
    output logic [SIZE-1:0] PCTargetW,
    output logic [31:0]     RetireCount
);

    localparam logic [5:0] LP_NREGS = 6'(NUM_REGS);

    logic [SIZE-1:0] r_regs [NUM_REGS];
    logic            r_pc_redirect;
    logic [SIZE-1:0] r_pc_target;
    logic [31:0]     r_retire_count;

    logic [SIZE-1:0] w_result;
    logic            w_wr_ok;
    logic            w_pc_wr;
    logic [SIZE-1:0] w_rd1;
    logic [SIZE-1:0] w_rd2;

    function automatic logic addr_live(input logic [4:0] a);
        return ({1'b0, a} < LP_NREGS) && !(ZERO_REG && (a == 5'd0));
    endfunction

    assign w_result = MemToRegW ? ReadDataW : ALUOutW;
    assign w_wr_ok  = RegWriteW && addr_live(WA3W);
    assign w_pc_wr  = RegWriteW && PCSrcW;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pc_redirect  <= 1'b0;
            r_pc_target    <= '0;
            r_retire_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[WA3W] <= w_result;
            end
            r_pc_redirect <= w_pc_wr;
            if (w_pc_wr) begin
                r_pc_target <= w_result;
            end
            // Dropped writes still retire an instruction, so they are counted.
            if (RegWriteW) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (addr_live(RA1D)) begin
            w_rd1 = r_regs[RA1D];
        end
        if (addr_live(RA2D)) begin
            w_rd2 = r_regs[RA2D];
        end
`ifdef WB_BYPASS_EN
        if (w_wr_ok && RST_N && (RA1D == WA3W)) begin
            w_rd1 = w_result;
        end
        if (w_wr_ok && RST_N && (RA2D == WA3W)) begin
            w_rd2 = w_result;
        end
`endif
    end

    assign RD1D        = w_rd1;
    assign RD2D        = w_rd2;
    assign ResultW     = w_result;
    assign PCRedirectW = r_pc_redirect;
    assign PCTargetW   = r_pc_target;
    assign RetireCount = r_retire_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Table-driven bench for wb_regfile: each vector carries its inputs and the
// expected combinational outputs before the edge plus registered outputs after it.
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        RegWriteW, MemToRegW, PCSrcW;
    logic [4:0]  WA3W, RA1D, RA2D;
    logic [31:0] ALUOutW, ReadDataW;
    logic [31:0] RD1D, RD2D, ResultW, PCTargetW, RetireCount;
    logic        PCRedirectW;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    wb_regfile dut (
        .CLK(CLK), .RST_N(RST_N), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .PCSrcW(PCSrcW), .WA3W(WA3W), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
        .RA1D(RA1D), .RA2D(RA2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
        .PCRedirectW(PCRedirectW), .PCTargetW(PCTargetW), .RetireCount(RetireCount)
    );

    typedef struct {
        logic        rst_n;
        logic        rw;
        logic        m2r;
        logic        pcs;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_res;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_redir;
        logic [31:0] e_tgt;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [17];
    vec_t sb_q [$];

    task automatic check32(input string name, input int idx,
                           input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    // Same-cycle read of the register being committed: forwarded only in the bypass build.
    function automatic logic [31:0] exp_read(input vec_t v, input logic [4:0] ra,
                                             input logic [31:0] pre);
`ifdef WB_BYPASS_EN
        if (v.rst_n && v.rw && v.wa != 5'd0 && ra == v.wa) return v.e_res;
`endif
        return pre;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge CLK);
        RST_N = v.rst_n; RegWriteW = v.rw; MemToRegW = v.m2r; PCSrcW = v.pcs;
        WA3W = v.wa; ALUOutW = v.alu; ReadDataW = v.rdat; RA1D = v.ra1; RA2D = v.ra2;
        sb_q.push_back(v);
        #4;
        e = sb_q.pop_front();
        check32("result", idx, ResultW, e.e_res);
        check32("rd1", idx, RD1D, exp_read(e, e.ra1, e.e_rd1));
        check32("rd2", idx, RD2D, exp_read(e, e.ra2, e.e_rd2));
        @(posedge CLK);
        #1;
        check32("redirect", idx, {31'd0, PCRedirectW}, {31'd0, e.e_redir});
        check32("target", idx, PCTargetW, e.e_tgt);
        check32("retire", idx, RetireCount, e.e_cnt);
    endtask

    initial begin
        vec_t w;
        //          rst rw m2r pcs wa   alu            rdat           ra1 ra2  res            rd1            rd2            rdr tgt           cnt
        tbl[0]  = '{1, 1, 0, 0, 3,  32'h1234,      32'h0,         0,  0,   32'h1234,      32'h0,         32'h0,         0, 32'h0,   32'd1};
        tbl[1]  = '{1, 1, 1, 0, 4,  32'hDEAD,      32'hCAFE,      3,  0,   32'hCAFE,      32'h1234,      32'h0,         0, 32'h0,   32'd2};
        tbl[2]  = '{1, 0, 0, 0, 0,  32'h0,         32'h0,         3,  4,   32'h0,         32'h1234,      32'hCAFE,      0, 32'h0,   32'd2};
        tbl[3]  = '{1, 1, 0, 0, 0,  32'hFFFFFFFF,  32'h0,         0,  3,   32'hFFFFFFFF,  32'h0,         32'h1234,      0, 32'h0,   32'd3};
        tbl[4]  = '{1, 0, 0, 0, 0,  32'h0,         32'h0,         0,  0,   32'h0,         32'h0,         32'h0,         0, 32'h0,   32'd3};
        tbl[5]  = '{1, 1, 0, 0, 5,  32'hA5A5,      32'h0,         5,  5,   32'hA5A5,      32'h0,         32'h0,         0, 32'h0,   32'd4};
        tbl[6]  = '{1, 0, 0, 0, 0,  32'h0,         32'h0,         5,  5,   32'h0,         32'hA5A5,      32'hA5A5,      0, 32'h0,   32'd4};
        tbl[7]  = '{1, 1, 0, 1, 6,  32'h100,       32'h0,         6,  0,   32'h100,       32'h0,         32'h0,         1, 32'h100, 32'd5};
        tbl[8]  = '{1, 0, 0, 1, 7,  32'h200,       32'h0,         6,  0,   32'h200,       32'h100,       32'h0,         0, 32'h100, 32'd5};
        tbl[9]  = '{1, 1, 1, 1, 7,  32'h0,         32'h300,       7,  4,   32'h300,       32'h0,         32'hCAFE,      1, 32'h300, 32'd6};
        tbl[10] = '{1, 1, 0, 0, 3,  32'h55,        32'h999,       3,  7,   32'h55,        32'h1234,      32'h300,       0, 32'h300, 32'd7};
        tbl[11] = '{1, 0, 1, 0, 0,  32'h77,        32'h88,        3,  31,  32'h88,        32'h55,        32'h0,         0, 32'h300, 32'd7};
        tbl[12] = '{1, 1, 0, 0, 31, 32'h80000001,  32'h0,         31, 31,  32'h80000001,  32'h0,         32'h0,         0, 32'h300, 32'd8};
        tbl[13] = '{1, 0, 0, 0, 0,  32'h0,         32'h0,         31, 6,   32'h0,         32'h80000001,  32'h100,       0, 32'h300, 32'd8};
        tbl[14] = '{0, 1, 0, 1, 9,  32'hABC,       32'h0,         3,  6,   32'hABC,       32'h55,        32'h100,       0, 32'h0,   32'd0};
        tbl[15] = '{1, 0, 0, 0, 0,  32'h0,         32'h0,         3,  6,   32'h0,         32'h0,         32'h0,         0, 32'h0,   32'd0};
        tbl[16] = '{1, 0, 0, 0, 0,  32'h0,         32'h0,         9,  31,  32'h0,         32'h0,         32'h0,         0, 32'h0,   32'd0};

        RST_N = 1'b0; RegWriteW = 1'b0; MemToRegW = 1'b0; PCSrcW = 1'b0;
        WA3W = '0; ALUOutW = '0; ReadDataW = '0; RA1D = '0; RA2D = '0;
        repeat (3) @(posedge CLK);
        #1;
        check32("reset_retire", -1, RetireCount, 32'd0);
        check32("reset_redirect", -1, {31'd0, PCRedirectW}, 32'd0);
        check32("reset_target", -1, PCTargetW, 32'd0);

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], i);
        end

        // Counter wrap: preload just below the wrap point, then two commits.
        @(negedge CLK);
        force dut.r_retire_count = 32'hFFFFFFFE;
        #1;
        release dut.r_retire_count;
        w = '{1, 1, 0, 0, 0, 32'h11, 32'h0, 0, 0, 32'h11, 32'h0, 32'h0, 0, 32'h0, 32'hFFFFFFFF};
        apply(w, 100);
        w = '{1, 1, 1, 0, 8, 32'h0, 32'h22, 8, 0, 32'h22, 32'h0, 32'h0, 0, 32'h0, 32'h0};
        apply(w, 101);
        w = '{1, 0, 0, 0, 0, 32'h0, 32'h0, 8, 8, 32'h0, 32'h22, 32'h22, 0, 32'h0, 32'h0};
        apply(w, 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
